// File: rtl/regfile_pkg.sv
// Shared widths and requester indices for the register-file writeback path.
// Imported by the arbiter top and by anything that drives its requesters.
package regfile_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 2 ** AW;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_DBG  = 2;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first valid requester at or after ptr_i, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int  c;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        c       = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr_i) + k;
            if (c >= NREQ) c = c - NREQ;
            if (!found && valid_i[c]) begin
                found      = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = PW'(c);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 register file: round-robin
// writeback arbitration plus a destination busy scoreboard for decode.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic              clk,
    input  logic              res,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              wen,
    output logic [AW-1:0]     wadd,
    output logic [DW-1:0]     wdi,
    input  logic              claim_valid,
    input  logic [AW-1:0]     claim_addr,
    output logic              claim_ready,
    input  logic [AW-1:0]     rd_addr1,
    input  logic [AW-1:0]     rd_addr2,
    output logic              rd_stall,
    output logic              wb_orphan
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;

    logic            wen_q, wen_d;
    addr_t           wadd_q, wadd_d;
    data_t           wdi_q, wdi_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            orphan_q, orphan_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .valid_i (req_valid),
        .ptr_i   (rr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign req_ready   = res ? '0 : gnt;
    assign claim_ready = ~res & claim_valid & ~busy_q[claim_addr];
    assign rd_stall    = busy_q[rd_addr1] | busy_q[rd_addr2];

    assign wen       = wen_q;
    assign wadd      = wadd_q;
    assign wdi       = wdi_q;
    assign wb_orphan = orphan_q;

    always_comb begin
        wen_d    = gnt_any;
        wadd_d   = wadd_q;
        wdi_d    = wdi_q;
        rr_d     = rr_q;
        busy_d   = busy_q;
        orphan_d = wen_q & ~busy_q[wadd_q];
        if (gnt_any) begin
            wadd_d = req_addr[int'(gnt_idx)*AW +: AW];
            wdi_d  = req_data[int'(gnt_idx)*DW +: DW];
            rr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
        // Clear before set so a same-edge claim keeps the register busy.
        if (wen_q) busy_d[wadd_q] = 1'b0;
        if (claim_ready) busy_d[claim_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wen_q    <= 1'b0;
            wadd_q   <= '0;
            wdi_q    <= '0;
            rr_q     <= '0;
            busy_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            wen_q    <= wen_d;
            wadd_q   <= wadd_d;
            wdi_q    <= wdi_d;
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            orphan_q <= orphan_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural 32x32 regfile
// that reinitialises each register to its own index on reset.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;

    logic              clk;
    logic              res;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              wen;
    logic [AW-1:0]     wadd;
    logic [DW-1:0]     wdi;
    logic              claim_valid;
    logic [AW-1:0]     claim_addr;
    logic              claim_ready;
    logic [AW-1:0]     rd_addr1;
    logic [AW-1:0]     rd_addr2;
    logic              rd_stall;
    logic              wb_orphan;

    logic [DW-1:0] mem [NREG];
    logic [DW-1:0] dout1;

    int tests;
    int failed;

    regfile_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .res         (res),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wen         (wen),
        .wadd        (wadd),
        .wdi         (wdi),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .claim_ready (claim_ready),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_stall    (rd_stall),
        .wb_orphan   (wb_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < NREG; i++) mem[i] <= DW'(i);
        end else if (wen) begin
            mem[wadd] <= wdi;
        end
    end

    assign dout1 = mem[rd_addr1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        tests       = 0;
        failed      = 0;
        res         = 1'b1;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        claim_valid = 1'b0;
        claim_addr  = '0;
        rd_addr1    = '0;
        rd_addr2    = '0;
        step();

        // Make r4 busy so reset has something to clear.
        res         = 1'b0;
        claim_valid = 1'b1;
        claim_addr  = 5'd4;
        rd_addr1    = 5'd4;
        #1;
        chk("claim_r4_ready", 64'(claim_ready), 64'd1);
        step();
        claim_valid = 1'b0;
        #1;
        chk("r4_busy_stall", 64'(rd_stall), 64'd1);

        // Reset with all requesters asking.
        res = 1'b1;
        set_req(REQ_ALU,  5'd10, 32'hA0A0_A0A0);
        set_req(REQ_LOAD, 5'd11, 32'hA1A1_A1A1);
        set_req(REQ_DBG,  5'd12, 32'hA2A2_A2A2);
        req_valid   = 3'b111;
        claim_valid = 1'b1;
        claim_addr  = 5'd6;
        #1;
        chk("ready_masked_in_res", 64'(req_ready), 64'd0);
        chk("claim_masked_in_res", 64'(claim_ready), 64'd0);
        step();
        res         = 1'b0;
        claim_valid = 1'b0;
        #1;
        chk("rst_wen", 64'(wen), 64'd0);
        chk("rst_wadd", 64'(wadd), 64'd0);
        chk("rst_stall", 64'(rd_stall), 64'd0);
        chk("rst_orphan", 64'(wb_orphan), 64'd0);

        // Rotation with all three valid, pointer starting at 0.
        chk("rr_g0", 64'(req_ready), 64'b001);
        step();
        chk("rr_g1", 64'(req_ready), 64'b010);
        chk("rr_wen0", 64'(wen), 64'd1);
        chk("rr_wdi0", 64'(wdi), 64'hA0A0_A0A0);
        step();
        chk("rr_g2", 64'(req_ready), 64'b100);
        chk("rr_wdi1", 64'(wdi), 64'hA1A1_A1A1);
        step();
        chk("rr_g3", 64'(req_ready), 64'b001);
        chk("rr_wdi2", 64'(wdi), 64'hA2A2_A2A2);
        chk("rr_wadd2", 64'(wadd), 64'd12);
        step();
        chk("rr_wdi0b", 64'(wdi), 64'hA0A0_A0A0);
        req_valid = '0;
        #1;
        chk("no_valid_no_grant", 64'(req_ready), 64'd0);
        step();
        chk("idle_wen", 64'(wen), 64'd0);
        chk("idle_wadd_hold", 64'(wadd), 64'd10);
        chk("idle_wdi_hold", 64'(wdi), 64'hA0A0_A0A0);

        // Claim r5, then commit DEADBEEF to it (pointer now at 1).
        claim_valid = 1'b1;
        claim_addr  = 5'd5;
        rd_addr1    = 5'd5;
        #1;
        chk("claim_r5_ready", 64'(claim_ready), 64'd1);
        step();
        claim_valid = 1'b0;
        set_req(REQ_ALU, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b001;
        #1;
        chk("r5_stall", 64'(rd_stall), 64'd1);
        chk("r5_grant", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        chk("r5_wen", 64'(wen), 64'd1);
        chk("r5_wadd", 64'(wadd), 64'd5);
        chk("r5_wdi", 64'(wdi), 64'hDEAD_BEEF);
        chk("r5_stall_inflight", 64'(rd_stall), 64'd1);
        step();
        chk("r5_stall_drop", 64'(rd_stall), 64'd0);
        chk("r5_dout1", 64'(dout1), 64'hDEAD_BEEF);
        chk("r5_no_orphan", 64'(wb_orphan), 64'd0);

        // WAW: claim r7, re-claim while busy, commit (pointer at 1).
        claim_valid = 1'b1;
        claim_addr  = 5'd7;
        rd_addr1    = 5'd7;
        rd_addr2    = 5'd7;
        #1;
        chk("claim_r7_ready", 64'(claim_ready), 64'd1);
        step();
        set_req(REQ_LOAD, 5'd7, 32'h0000_0077);
        req_valid = 3'b010;
        #1;
        chk("reclaim_r7_reject", 64'(claim_ready), 64'd0);
        chk("r7_grant", 64'(req_ready), 64'b010);
        step();
        claim_valid = 1'b0;
        req_valid   = '0;
        chk("r7_busy_kept", 64'(rd_stall), 64'd1);
        chk("r7_wadd", 64'(wadd), 64'd7);
        step();
        chk("r7_cleared", 64'(rd_stall), 64'd0);
        chk("r7_no_orphan", 64'(wb_orphan), 64'd0);

        // Orphan commit to r7 on the same edge as a new claim of r7.
        set_req(REQ_DBG, 5'd7, 32'h0000_7777);
        req_valid = 3'b100;
        #1;
        chk("r7b_grant", 64'(req_ready), 64'b100);
        step();
        req_valid   = '0;
        claim_valid = 1'b1;
        claim_addr  = 5'd7;
        #1;
        chk("r7b_claim_ready", 64'(claim_ready), 64'd1);
        step();
        claim_valid = 1'b0;
        #1;
        chk("set_wins", 64'(rd_stall), 64'd1);
        chk("r7b_orphan", 64'(wb_orphan), 64'd1);
        step();
        chk("r7b_orphan_end", 64'(wb_orphan), 64'd0);
        chk("r7b_still_busy", 64'(rd_stall), 64'd1);

        // Unclaimed write to r3 from the load port (pointer at 0).
        set_req(REQ_LOAD, 5'd3, 32'h1234_5678);
        req_valid = 3'b010;
        #1;
        chk("r3_grant", 64'(req_ready), 64'b010);
        step();
        req_valid = '0;
        rd_addr1  = 5'd3;
        rd_addr2  = 5'd3;
        chk("r3_wen", 64'(wen), 64'd1);
        chk("r3_wadd", 64'(wadd), 64'd3);
        chk("r3_orphan_pre", 64'(wb_orphan), 64'd0);
        step();
        chk("r3_orphan", 64'(wb_orphan), 64'd1);
        chk("r3_not_busy", 64'(rd_stall), 64'd0);
        chk("r3_dout1", 64'(dout1), 64'h1234_5678);
        step();
        chk("r3_orphan_end", 64'(wb_orphan), 64'd0);

        // Reset lands on the commit edge of a write to r9 (pointer at 2).
        set_req(REQ_ALU, 5'd9, 32'h9999_9999);
        req_valid = 3'b001;
        rd_addr1  = 5'd9;
        rd_addr2  = 5'd9;
        #1;
        chk("r9_grant", 64'(req_ready), 64'b001);
        step();
        req_valid = '0;
        res       = 1'b1;
        chk("r9_wen", 64'(wen), 64'd1);
        step();
        res         = 1'b0;
        claim_valid = 1'b1;
        claim_addr  = 5'd9;
        #1;
        chk("r9_rst_wen", 64'(wen), 64'd0);
        chk("r9_rst_wadd", 64'(wadd), 64'd0);
        chk("r9_dout1", 64'(dout1), 64'd9);
        chk("r9_not_busy", 64'(rd_stall), 64'd0);
        chk("r9_claim_ready", 64'(claim_ready), 64'd1);
        step();
        claim_valid = 1'b0;
        step();
        chk("r9_dout1_kept", 64'(dout1), 64'd9);
        chk("r9_wen_idle", 64'(wen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
